// File: rtl/ling_add_arbiter.sv
// Round-robin arbiter in front of one shared 32-bit sparse-4 Ling adder.
// Each 64-bit op takes LO, HI and an optional INC pass through the same adder.

module L32_node_adder (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] sum
);
  // Ling pseudo-carry: H[i] = g[i] | t[i-1] & H[i-1]. The real carry out of bit i is t[i] & H[i].
  logic [31:0] g;
  logic [31:0] p;
  logic [30:0] t;
  logic [31:0] th;
  logic [7:0]  bg;
  logic [7:0]  bt;
  logic [7:0]  pg [0:3];
  logic [7:0]  pt [0:3];
  logic [7:0]  hin;
  logic        hprev;
  logic        cin;

  assign g  = a & b;
  assign p  = a ^ b;
  assign t  = a[30:0] | b[30:0];
  assign th = {t, 1'b0};

  always_comb begin
    bg = '0;
    bt = '0;
    for (int k = 0; k < 8; k++) begin
      bg[k] = g[4*k];
      bt[k] = th[4*k];
      for (int j = 1; j < 4; j++) begin
        bg[k] = g[4*k+j] | (th[4*k+j] & bg[k]);
        bt[k] = th[4*k+j] & bt[k];
      end
    end
  end

  // Kogge-Stone prefix over the eight 4-bit blocks; only block-boundary H values are produced.
  always_comb begin
    pg[0] = bg;
    pt[0] = bt;
    pg[1] = '0; pg[2] = '0; pg[3] = '0;
    pt[1] = '0; pt[2] = '0; pt[3] = '0;
    for (int lvl = 0; lvl < 3; lvl++) begin
      for (int k = 0; k < 8; k++) begin
        if (k >= (1 << lvl)) begin
          pg[lvl+1][k] = pg[lvl][k] | (pt[lvl][k] & pg[lvl][k-(1<<lvl)]);
          pt[lvl+1][k] = pt[lvl][k] & pt[lvl][k-(1<<lvl)];
        end else begin
          pg[lvl+1][k] = pg[lvl][k];
          pt[lvl+1][k] = pt[lvl][k];
        end
      end
    end
  end

  // Inside each block the pseudo-carry ripples from the block-entry value.
  always_comb begin
    hin = '0;
    for (int k = 1; k < 8; k++) hin[k] = pg[3][k-1];
    sum   = '0;
    hprev = 1'b0;
    cin   = 1'b0;
    for (int i = 0; i < 32; i++) begin
      if ((i % 4) == 0) hprev = hin[i/4];
      cin    = (i == 0) ? 1'b0 : (th[i] & hprev);
      sum[i] = p[i] ^ cin;
      hprev  = g[i] | (th[i] & hprev);
    end
  end
endmodule

module ling_add_arbiter #(
  parameter  int N_REQ = 4,
  localparam int IDW   = $clog2(N_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req_valid,
  output logic [N_REQ-1:0]   req_ready,
  input  logic [N_REQ-1:0]   req_wide,
  input  logic [N_REQ*64-1:0] req_a,
  input  logic [N_REQ*64-1:0] req_b,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [IDW-1:0]     rsp_id,
  output logic [63:0]        rsp_sum,
  output logic               rsp_cout,
  output logic [2:0]         dbg_state,
  output logic [IDW-1:0]     dbg_ptr
);
  // Handshakes: a transfer happens on a rising edge where valid & ready are both high;
  // req_ready never depends on anything but state, ptr, rst and req_valid.
  typedef enum logic [2:0] {IDLE, LO, HI, INC, DONE} state_t;

  state_t          state, state_nxt;
  logic [IDW-1:0]  ptr;
  logic [IDW-1:0]  grant;
  logic            grant_vld;
  logic            accept;
  logic [31:0]     op_a, op_b, hi_a, hi_b;
  logic [31:0]     add_sum;
  logic [31:0]     s_lo, s_hi;
  logic            c_lo, c_hi, c_inc;
  logic            pass_c;
  logic            wide_r;
  logic [IDW-1:0]  id_r;

  L32_node_adder u_add (.a(op_a), .b(op_b), .sum(add_sum));

  assign pass_c    = (op_a[31] & op_b[31]) | ((op_a[31] | op_b[31]) & ~add_sum[31]);
  assign dbg_state = state;
  assign dbg_ptr   = ptr;

  always_comb begin
    grant     = '0;
    grant_vld = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!grant_vld && req_valid[(int'(ptr) + k) % N_REQ]) begin
        grant_vld = 1'b1;
        grant     = IDW'((int'(ptr) + k) % N_REQ);
      end
    end
  end

  always_comb begin
    accept    = (state == IDLE) && grant_vld && !rst;
    req_ready = '0;
    if (accept) req_ready[grant] = 1'b1;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = LO;
      LO:   state_nxt = wide_r ? HI : DONE;
      HI:   state_nxt = c_lo ? INC : DONE;
      INC:  state_nxt = DONE;
      DONE: if (rsp_valid && rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_sum   <= '0;
      rsp_cout  <= 1'b0;
      op_a      <= '0;
      op_b      <= '0;
      hi_a      <= '0;
      hi_b      <= '0;
      s_lo      <= '0;
      s_hi      <= '0;
      c_lo      <= 1'b0;
      c_hi      <= 1'b0;
      c_inc     <= 1'b0;
      wide_r    <= 1'b0;
      id_r      <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (accept) begin
          op_a   <= req_a[int'(grant)*64 +: 32];
          op_b   <= req_b[int'(grant)*64 +: 32];
          hi_a   <= req_a[int'(grant)*64+32 +: 32];
          hi_b   <= req_b[int'(grant)*64+32 +: 32];
          wide_r <= req_wide[grant];
          id_r   <= grant;
          c_hi   <= 1'b0;
          c_inc  <= 1'b0;
          ptr    <= (grant == IDW'(N_REQ-1)) ? '0 : grant + 1'b1;
        end
        LO: begin
          s_lo <= add_sum;
          c_lo <= pass_c;
          op_a <= hi_a;
          op_b <= hi_b;
        end
        HI: begin
          s_hi <= add_sum;
          c_hi <= pass_c;
          op_a <= add_sum;
          op_b <= 32'd1;
        end
        INC: begin
          s_hi  <= add_sum;
          c_inc <= &op_a;
        end
        DONE: begin
          // Result registers load once on entry and stay frozen until the handshake.
          if (!rsp_valid) begin
            rsp_valid <= 1'b1;
            rsp_id    <= id_r;
            rsp_sum   <= wide_r ? {s_hi, s_lo} : {32'h0, s_lo};
            rsp_cout  <= wide_r ? (c_hi | c_inc) : c_lo;
          end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: doc/ling_add_arbiter.md
LING_ADD_ARBITER -- requirements
Module: ling_add_arbiter

Interface
REQ-001 The module SHALL have one parameter: N_REQ, default 4, the number of requesters (2..8); ID width is IDW = clog2(N_REQ).
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst  input  1  synchronous active-high reset, sampled on rising clk.
REQ-004 req_valid  input  N_REQ  per-requester request valid.
REQ-005 req_ready  output  N_REQ  per-requester accept; at most one bit high.
REQ-006 req_wide  input  N_REQ  per-requester op size: 1 = 64-bit add, 0 = 32-bit add.
REQ-007 req_a  input  N_REQ*64  operand A; slice i = bits [64i+63:64i].
REQ-008 req_b  input  N_REQ*64  operand B, same packing.
REQ-009 rsp_valid  output  1  result valid.
REQ-010 rsp_ready  input  1  result consumer ready.
REQ-011 rsp_id  output  IDW  index of the requester that owns the result.
REQ-012 rsp_sum  output  64  sum; bits [63:32] are 0 for narrow ops.
REQ-013 rsp_cout  output  1  carry out of bit 31 (narrow) or bit 63 (wide).

Function
REQ-014 The block SHALL share a single instance of the 32-bit sparse-4 Ling adder (L32_node_adder, no carry-in) across all requesters; no other adder is permitted.
REQ-015 The adder operands SHALL be driven from registers, and the adder sum SHALL be captured into a register at the end of each pass; one pass = one cycle.
REQ-016 The FSM SHALL have five states: IDLE, LO, HI, INC, DONE; reset state is IDLE.
REQ-017 IDLE: req_ready[g] = req_valid[g] for the round-robin winner g, and all other bits are 0.
- Winner search: start at ptr and take the first valid index upward, modulo N_REQ.
- req_ready SHALL be 0 in every state other than IDLE.
REQ-018 On accept (req_valid[g] & req_ready[g]) the block SHALL:
- latch A, B, wide and g;
- set ptr <= (g+1) mod N_REQ;
- move to LO.
REQ-019 LO: the block SHALL compute the low-half sum s_lo = A[31:0] + B[31:0] and form c_lo = (a31&b31) | ((a31|b31) & ~s_lo31).
- Next state: DONE if narrow, HI if wide.
REQ-020 HI: the block SHALL compute the high-half sum s_hi = A[63:32] + B[63:32] and form c_hi by the same carry formula.
- Next state: INC if c_lo = 1, else DONE.
REQ-021 INC: the block SHALL reuse the adder with operands s_hi and 32'h1 and replace s_hi with the result.
- c_inc = 1 iff the previous s_hi = 32'hFFFFFFFF.
- Next state: DONE.
REQ-022 Result fields:
- rsp_cout = c_lo (narrow) or c_hi | c_inc (wide); c_hi and c_inc are never both 1.
- rsp_sum = {s_hi, s_lo} (wide) or {32'h0, s_lo} (narrow).
REQ-023 Latency, counted as rising edges after the accept edge until rsp_valid is high:
- narrow: 2;
- wide without carry: 3;
- wide with carry: 4.
REQ-024 DONE: rsp_valid SHALL be 1, and rsp_sum, rsp_cout and rsp_id SHALL be held stable until rsp_valid & rsp_ready, after which the next state is IDLE.
- No new accept is allowed in the same cycle as that handshake.
REQ-025 rsp_valid SHALL be 0 in every state except DONE.
REQ-026 Changes of req_* inputs after accept SHALL NOT affect the result in flight.
REQ-027 Requests with req_valid low in IDLE SHALL be skipped with no penalty; ptr SHALL change only on accept.

Reset
REQ-028 When rst = 1, on the next edge the block SHALL apply these reset values:
- state = IDLE, ptr = 0;
- rsp_valid = 0, req_ready = 0;
- rsp_id = 0, rsp_sum = 0, rsp_cout = 0.
REQ-029 Reset in any state SHALL abort the operation in flight; no response is ever produced for the aborted request.
REQ-030 req_ready SHALL be 0 while rst is high.

Verification
REQ-031 Narrow carry: req0 with a=0xFFFFFFFF, b=1, wide=0 -> rsp_id=0, rsp_sum=0, rsp_cout=1, rsp_valid 2 edges after accept.
REQ-032 Wide with increment: a=0x00000000_FFFFFFFF, b=1 -> rsp_sum=0x00000001_00000000, rsp_cout=0, latency 4.
REQ-033 Wide full wrap: a=0xFFFFFFFF_FFFFFFFF, b=1 -> rsp_sum=0, rsp_cout=1 (c_inc path), latency 4; and a=0x80000000_00000000, b=0x80000000_00000000 -> rsp_sum=0, rsp_cout=1, latency 3.
REQ-034 Fairness: after reset, all four req_valid held high with rsp_ready=1 -> grant order 0,1,2,3,0, and each request is accepted exactly once per round.
REQ-035 Backpressure: rsp_ready held 0 for 5 cycles in DONE -> rsp_* stable, req_ready=0 throughout; rsp_ready=1 -> one handshake, then IDLE.
REQ-036 Reset mid-op: rst asserted during HI of a wide op from req2 -> next cycle rsp_valid=0, ptr=0; no response for req2; a following req1 request completes normally.
